alu_console: RTL and testbench
==============================

Name: alu_console

Overview:
- Parametrised successor to the board-level ALU operand-entry front end.
- Conditions active-low push buttons with a 2-flop synchroniser, a debouncer and auto-repeat.
- Runs a four-stage entry FSM that holds the ALU's A, B and opcode registers, and captures the ALU result and flags.
- Drives a packed hex-nibble bus for the segment encoders/manager, plus stage LEDs and the buzzer. The ALU stays external and combinational.

Parameters:
- WIDTH, 8: operand/result/flag width; must be a multiple of 4.
- OP_WIDTH, 8: opcode width; must be at most WIDTH.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a level change is accepted.
- REPEAT_DELAY, 25000000: hold cycles before inc/dec auto-repeat starts; 0 disables repeat.
- REPEAT_RATE, 5000000: cycles between repeat events.
- BEEP_CYCLES, 2500000: buzzer pulse length per accepted event.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_inc_n  in  1  increment button, active low, asynchronous.
- btn_dec_n  in  1  decrement button, active low, asynchronous.
- btn_next_n  in  1  next-stage button, active low, asynchronous.
- btn_clr_n  in  1  clear button, active low, asynchronous.
- alu_a  out  WIDTH  operand A register.
- alu_b  out  WIDTH  operand B register.
- alu_op  out  OP_WIDTH  opcode register.
- alu_out  in  WIDTH  ALU result (combinational from alu_a, alu_b, alu_op).
- alu_flags  in  WIDTH  ALU flags.
- disp_hex  out  2*WIDTH  nibble bus; MS nibble goes to the leftmost digit.
- stage  out  2  current FSM state.
- stage_led  out  4  one-hot stage indicator, active low.
- beep  out  1  buzzer drive.

Behaviour:
- Reset is asynchronous and active low; clk is the only clock. Reset is decided, not optional.
- Reset values:
  - alu_a, alu_b, alu_op, the result/flag capture registers, disp_hex: 0.
  - stage = S_A; stage_led = 4'b1110; beep = 0.
  - Synchroniser flops and debounced levels: 1 (released).
  - All counters: 0.
- Conditioning, per button:
  - 2-flop synchroniser feeds a counter. The counter resets whenever the synced value equals the debounced level; on reaching DEBOUNCE_CYCLES-1 the debounced level flips.
  - press event = 1-cycle pulse when the debounced level falls 1->0. Releases produce no event.
  - Latency: press event fires at synced-low + DEBOUNCE_CYCLES.
- Auto-repeat (inc/dec only):
  - While the debounced level stays low, a hold counter runs. After REPEAT_DELAY cycles it issues an event, then one every REPEAT_RATE cycles.
  - Release clears the hold counter.
- Event priority per cycle: clr > next > inc > dec. Lower-priority events in the same cycle are dropped, not queued.
- FSM states: S_A=0, S_B=1, S_OP=2, S_RES=3.
  - next: S_A->S_B->S_OP->S_RES. On entering S_RES, capture alu_out into res and alu_flags into flg.
  - next in S_RES: go to S_A and zero alu_a, alu_b, alu_op.
  - inc/dec modify the current target (S_A: alu_a, S_B: alu_b, S_OP: alu_op). Arithmetic is modulo 2^width, so FF+1=00 and 00-1=FF.
  - inc/dec in S_RES are ignored, and beep does not fire for them.
  - clr in S_A/S_B/S_OP: zero the current target only, stage unchanged.
  - clr in S_RES: zero alu_a, alu_b, alu_op, res, flg; go to S_A.
- Display (registered; updates the cycle after the state/register change):
  - S_A, S_B: {alu_a, alu_b}.
  - S_OP: {alu_op zero-extended to WIDTH, WIDTH'0}.
  - S_RES: {res, flg}. Captured values stay frozen even if the ALU inputs change.
- stage_led: bit[stage] = 0, all other bits = 1.
- beep: reloads a BEEP_CYCLES down-counter on every accepted (non-ignored) event. beep = counter != 0. Back-to-back events retrigger the full length.
- Reset mid-operation: all state returns to its reset value at once, including any in-progress debounce/repeat.
  - A button held through reset deassertion yields exactly one press after DEBOUNCE_CYCLES, then repeat behaviour as normal.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

Decomposition:
- Shared package alu_console_pkg:
  - Stage encoding constants S_A/S_B/S_OP/S_RES.
  - Event priority order.
  - Default timing constants for the 50 MHz board clock.
- One natural sub-module: button_conditioner (params DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE; ports clk, rst_n, btn_n, press, level).
  - Instantiated 4 times.
  - next and clr instances use REPEAT_DELAY=0.

Test Plan (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BEEP_CYCLES=3, WIDTH=8):
1. Entry flow: press inc 3 times in S_A, next, dec once in S_B, next.
   - Required: alu_a=03, alu_b=FF, stage=2, disp_hex=16'h0000 after op=00.
   - Then inc 2 times: disp_hex=16'h0200.
2. Result capture: in S_OP with the ALU model returning out=5A, flags=81, press next.
   - Required: stage=3, disp_hex=16'h5A81.
   - Then change alu_out to 00: disp_hex stays 5A81.
   - Then next: stage=0, alu_a=alu_b=alu_op=00.
3. Debounce: 3-cycle low glitch on btn_inc_n -> no change.
   - 10-cycle low -> exactly one increment, on cycle 2+4 after the edge.
4. Auto-repeat: hold inc 40 cycles after debounce.
   - Required: alu_a = 1 + 1 + floor((40-20)/5) = 06.
   - Release then re-hold: the delay restarts.
5. Priority and clear: assert next and inc presses in the same cycle in S_A with a=07.
   - Required: stage=1, a stays 07.
   - Then clr in S_RES: stage=0, all registers 00, beep high for 3 cycles.
6. Reset: drop rst_n mid-repeat with a=10.
   - Required: all outputs at reset values immediately (async).
   - Button held through release: one press after 4+2 cycles, a=01.

Source files
------------

// File: rtl/alu_console_pkg.sv
// Shared definitions for the ALU operand-entry console: stage codes, event
// priority and default timing for the 50 MHz board clock.
package alu_console_pkg;

  localparam logic [1:0] S_A   = 2'd0;
  localparam logic [1:0] S_B   = 2'd1;
  localparam logic [1:0] S_OP  = 2'd2;
  localparam logic [1:0] S_RES = 2'd3;

  // Bit positions of each button inside the packed press/level vectors.
  localparam int unsigned BTN_INC  = 0;
  localparam int unsigned BTN_DEC  = 1;
  localparam int unsigned BTN_NEXT = 2;
  localparam int unsigned BTN_CLR  = 3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
  localparam int unsigned DEF_REPEAT_RATE     = 5_000_000;
  localparam int unsigned DEF_BEEP_CYCLES     = 2_500_000;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_CLR  = 3'd1,
    EV_NEXT = 3'd2,
    EV_INC  = 3'd3,
    EV_DEC  = 3'd4
  } event_e;

  // Only the winning event of a cycle survives; the rest are dropped.
  function automatic event_e pick_event(input logic [3:0] press);
    if (press[BTN_CLR])       return EV_CLR;
    else if (press[BTN_NEXT]) return EV_NEXT;
    else if (press[BTN_INC])  return EV_INC;
    else if (press[BTN_DEC])  return EV_DEC;
    else                      return EV_NONE;
  endfunction

endpackage

// File: rtl/alu_console_button_conditioner.sv
// One push button: 2-flop synchroniser, level debouncer, press pulse on the
// debounced falling edge and optional hold-to-repeat.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_RATE     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press,
  output logic level
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            flip;
  logic            rep_fire;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q + 1'b1;
    flip     = 1'b0;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      flip     = 1'b1;
      db_cnt_d = '0;
      level_d  = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      level_q  <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // The press is combinational with the flip so it lands on the same edge
  // that commits the new debounced level.
  assign press = (flip & level_q) | rep_fire;
  assign level = level_q;

  generate
    if (REPEAT_DELAY == 0) begin : g_no_repeat
      assign rep_fire = 1'b0;
    end else begin : g_repeat
      localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int unsigned HW = $clog2(HOLD_MAX + 1);
      localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
      localparam logic [HW-1:0] RATE_LAST  = HW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

      logic [HW-1:0] hold_q, hold_d;
      logic          rep_phase_q, rep_phase_d;

      // First repeat waits the full delay, later ones only the rate period.
      assign rep_fire = !level_q && (hold_q == (rep_phase_q ? RATE_LAST : DELAY_LAST));

      always_comb begin
        hold_d      = hold_q + 1'b1;
        rep_phase_d = rep_phase_q;
        if (level_q) begin
          hold_d      = '0;
          rep_phase_d = 1'b0;
        end else if (rep_fire) begin
          hold_d      = '0;
          rep_phase_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_q      <= '0;
          rep_phase_q <= 1'b0;
        end else begin
          hold_q      <= hold_d;
          rep_phase_q <= rep_phase_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/alu_console.sv
// Operand-entry front end for an external combinational ALU: four buttons drive
// a four-stage FSM holding A, B and opcode, then freeze the result and flags.
module alu_console
  import alu_console_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned OP_WIDTH        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned BEEP_CYCLES     = DEF_BEEP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_inc_n,
  input  logic                 btn_dec_n,
  input  logic                 btn_next_n,
  input  logic                 btn_clr_n,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OP_WIDTH-1:0]  alu_op,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic [WIDTH-1:0]     alu_flags,
  output logic [2*WIDTH-1:0]   disp_hex,
  output logic [1:0]           stage,
  output logic [3:0]           stage_led,
  output logic                 beep
);

  localparam int unsigned BEEP_W = (BEEP_CYCLES > 0) ? $clog2(BEEP_CYCLES + 1) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);

  logic [3:0] btn_n_w, press_w, level_w;
  logic       unused_levels;

  assign btn_n_w = {btn_clr_n, btn_next_n, btn_dec_n, btn_inc_n};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   ((gi == BTN_INC || gi == BTN_DEC) ? REPEAT_DELAY : 0),
        .REPEAT_RATE    (REPEAT_RATE)
      ) u_cond (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_n_w[gi]),
        .press(press_w[gi]),
        .level(level_w[gi])
      );
    end
  endgenerate

  assign unused_levels = ^level_w;

  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0]    res_q, res_d, flg_q, flg_d;
  logic [1:0]          stage_q, stage_d;
  logic [2*WIDTH-1:0]  disp_q, disp_d;
  logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
  event_e              ev;
  logic                accept;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flg_d   = flg_q;
    stage_d = stage_q;
    ev      = pick_event(press_w);
    accept  = (ev != EV_NONE) && !((stage_q == S_RES) && (ev == EV_INC || ev == EV_DEC));

    case (ev)
      EV_CLR: begin
        if (stage_q == S_RES) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = '0;
          res_d   = '0;
          flg_d   = '0;
          stage_d = S_A;
        end else if (stage_q == S_A) begin
          a_d = '0;
        end else if (stage_q == S_B) begin
          b_d = '0;
        end else begin
          op_d = '0;
        end
      end
      EV_NEXT: begin
        case (stage_q)
          S_A:  stage_d = S_B;
          S_B:  stage_d = S_OP;
          S_OP: begin
            stage_d = S_RES;
            res_d   = alu_out;
            flg_d   = alu_flags;
          end
          default: begin
            stage_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
          end
        endcase
      end
      EV_INC: begin
        case (stage_q)
          S_A:     a_d  = a_q + 1'b1;
          S_B:     b_d  = b_q + 1'b1;
          S_OP:    op_d = op_q + 1'b1;
          default: ;
        endcase
      end
      EV_DEC: begin
        case (stage_q)
          S_A:     a_d  = a_q - 1'b1;
          S_B:     b_d  = b_q - 1'b1;
          S_OP:    op_d = op_q - 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase

    beep_cnt_d = beep_cnt_q;
    if (accept)
      beep_cnt_d = BEEP_LOAD;
    else if (beep_cnt_q != '0)
      beep_cnt_d = beep_cnt_q - 1'b1;

    // Display follows the registered state, so it trails changes by a cycle.
    case (stage_q)
      S_A, S_B: disp_d = {a_q, b_q};
      S_OP:     disp_d = {WIDTH'(op_q), {WIDTH{1'b0}}};
      default:  disp_d = {res_q, flg_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      flg_q      <= '0;
      stage_q    <= S_A;
      disp_q     <= '0;
      beep_cnt_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
      stage_q    <= stage_d;
      disp_q     <= disp_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  always_comb begin
    stage_led          = 4'b1111;
    stage_led[stage_q] = 1'b0;
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign stage    = stage_q;
  assign disp_hex = disp_q;
  assign beep     = (beep_cnt_q != '0);

endmodule

// File: tb/tb_alu_console.sv
// Directed bench for alu_console: stimulus pushes expected snapshots into a
// queue and a negedge monitor pops and compares them against the outputs.
module tb_alu_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn_n = 4'hF;   // 0 inc, 1 dec, 2 next, 3 clr
  logic [7:0]  alu_out_m = 8'h00;
  logic [7:0]  alu_flags_m = 8'h00;
  logic [7:0]  alu_a, alu_b, alu_op;
  logic [15:0] disp_hex;
  logic [1:0]  stage;
  logic [3:0]  stage_led;
  logic        beep;

  always #5 clk = ~clk;

  alu_console #(
    .WIDTH(8), .OP_WIDTH(8), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20), .REPEAT_RATE(5), .BEEP_CYCLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_inc_n(btn_n[0]), .btn_dec_n(btn_n[1]),
    .btn_next_n(btn_n[2]), .btn_clr_n(btn_n[3]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out_m), .alu_flags(alu_flags_m),
    .disp_hex(disp_hex), .stage(stage), .stage_led(stage_led), .beep(beep)
  );

  // mask bits: 0 a, 1 b, 2 op, 3 stage, 4 disp, 5 led, 6 beep
  typedef struct packed {
    logic [6:0]  mask;
    logic [7:0]  a, b, op;
    logic [1:0]  st;
    logic [15:0] disp;
    logic [3:0]  led;
    logic        bp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.mask[0]) cmp({nm, ".a"},     {8'h00, alu_a},  {8'h00, e.a});
      if (e.mask[1]) cmp({nm, ".b"},     {8'h00, alu_b},  {8'h00, e.b});
      if (e.mask[2]) cmp({nm, ".op"},    {8'h00, alu_op}, {8'h00, e.op});
      if (e.mask[3]) cmp({nm, ".stage"}, {14'h0, stage},  {14'h0, e.st});
      if (e.mask[4]) cmp({nm, ".disp"},  disp_hex,        e.disp);
      if (e.mask[5]) cmp({nm, ".led"},   {12'h0, stage_led}, {12'h0, e.led});
      if (e.mask[6]) cmp({nm, ".beep"},  {15'h0, beep},   {15'h0, e.bp});
    end
  end

  task automatic push_exp(input string nm, input logic [6:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] op, input logic [1:0] st,
                          input logic [15:0] d, input logic bp);
    exp_t e;
    e.mask = m; e.a = a; e.b = b; e.op = op; e.st = st; e.disp = d; e.bp = bp;
    e.led  = 4'hF & ~(4'b0001 << st);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_a(input string nm, input logic [7:0] v);
    push_exp(nm, 7'b0000001, v, 8'h0, 8'h0, 2'd0, 16'h0, 1'b0);
  endtask
  task automatic exp_b(input string nm, input logic [7:0] v);
    push_exp(nm, 7'b0000010, 8'h0, v, 8'h0, 2'd0, 16'h0, 1'b0);
  endtask
  task automatic exp_op(input string nm, input logic [7:0] v);
    push_exp(nm, 7'b0000100, 8'h0, 8'h0, v, 2'd0, 16'h0, 1'b0);
  endtask
  task automatic exp_stage(input string nm, input logic [1:0] st);
    push_exp(nm, 7'b0101000, 8'h0, 8'h0, 8'h0, st, 16'h0, 1'b0);
  endtask
  task automatic exp_disp(input string nm, input logic [15:0] d);
    push_exp(nm, 7'b0010000, 8'h0, 8'h0, 8'h0, 2'd0, d, 1'b0);
  endtask
  task automatic exp_beep(input string nm, input logic bp);
    push_exp(nm, 7'b1000000, 8'h0, 8'h0, 8'h0, 2'd0, 16'h0, bp);
  endtask
  task automatic exp_reset(input string nm);
    push_exp(nm, 7'b1111111, 8'h0, 8'h0, 8'h0, 2'd0, 16'h0, 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Short press well below the repeat delay, then time for release and display.
  task automatic tap(input int idx);
    btn_n[idx] = 1'b0;
    tick(8);
    btn_n[idx] = 1'b1;
    tick(12);
  endtask

  initial begin
    tick(3);
    exp_reset("reset");
    rst_n = 1'b1;
    tick(2);

    // 1. entry flow
    repeat (3) tap(0);
    exp_a("t1_a_after_inc3", 8'h03);
    exp_disp("t1_disp_sa", 16'h0300);
    tap(2);
    exp_stage("t1_stage_b", 2'd1);
    tap(1);
    exp_b("t1_b_wrap", 8'hFF);
    exp_disp("t1_disp_sb", 16'h03FF);
    tap(2);
    exp_stage("t1_stage_op", 2'd2);
    exp_disp("t1_disp_op0", 16'h0000);
    repeat (2) tap(0);
    exp_op("t1_op", 8'h02);
    exp_disp("t1_disp_op2", 16'h0200);

    // 2. result capture and freeze
    alu_out_m = 8'h5A; alu_flags_m = 8'h81;
    tap(2);
    exp_stage("t2_stage_res", 2'd3);
    exp_disp("t2_disp_res", 16'h5A81);
    alu_out_m = 8'h00; alu_flags_m = 8'h00;
    tick(5);
    exp_disp("t2_disp_frozen", 16'h5A81);
    tap(2);
    push_exp("t2_wrap_to_a", 7'b0101111, 8'h00, 8'h00, 8'h00, 2'd0, 16'h0, 1'b0);

    // 3. debounce: glitch rejected, clean press lands 2+4 edges after the drive
    btn_n[0] = 1'b0; tick(3); btn_n[0] = 1'b1; tick(12);
    exp_a("t3_glitch", 8'h00);
    btn_n[0] = 1'b0;
    tick(5);
    exp_a("t3_before_edge6", 8'h00);
    tick(1);
    exp_a("t3_at_edge6", 8'h01);
    tick(4); btn_n[0] = 1'b1; tick(12);
    exp_a("t3_single_inc", 8'h01);

    // clear in S_A zeroes A only
    tap(3);
    push_exp("t3_clr_sa", 7'b0101001, 8'h00, 8'h00, 8'h00, 2'd0, 16'h0, 1'b0);

    // 4. auto-repeat: press plus repeats at +20,+25,+30,+35,+40
    btn_n[0] = 1'b0; tick(42); btn_n[0] = 1'b1; tick(12);
    exp_a("t4_repeat", 8'h06);
    btn_n[0] = 1'b0; tick(16); btn_n[0] = 1'b1; tick(12);
    exp_a("t4_delay_restart", 8'h07);

    // 5. priority next > inc, then clear from S_RES with beep length
    btn_n[0] = 1'b0; btn_n[2] = 1'b0;
    tick(8);
    btn_n[0] = 1'b1; btn_n[2] = 1'b1;
    tick(12);
    push_exp("t5_priority", 7'b0101011, 8'h07, 8'h00, 8'h00, 2'd1, 16'h0, 1'b0);
    alu_out_m = 8'h33; alu_flags_m = 8'h44;
    tap(2); tap(2);
    push_exp("t5_res", 7'b0111000, 8'h0, 8'h0, 8'h0, 2'd3, 16'h3344, 1'b0);
    btn_n[3] = 1'b0;
    tick(5);
    exp_beep("t5_beep_idle", 1'b0);
    tick(1);
    push_exp("t5_clr_res", 7'b1101111, 8'h00, 8'h00, 8'h00, 2'd0, 16'h0, 1'b1);
    tick(1); exp_beep("t5_beep_2", 1'b1);
    tick(1); exp_beep("t5_beep_3", 1'b1);
    tick(1); exp_beep("t5_beep_off", 1'b0);
    btn_n[3] = 1'b1; tick(12);
    exp_disp("t5_disp_cleared", 16'h0000);

    // 6. async reset mid-repeat, button held through release
    btn_n[0] = 1'b0;
    for (int i = 0; i < 300 && alu_a != 8'h10; i++) tick(1);
    if (alu_a != 8'h10) begin
      checks++;
      errors++;
      $display("FAIL t6_reach_10: got %h, expected 10 within 300 cycles", alu_a);
    end
    #1;
    rst_n = 1'b0;
    #1;
    exp_reset("t6_async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    exp_a("t6_before_press", 8'h00);
    tick(1);
    exp_a("t6_held_press", 8'h01);
    tick(10);
    exp_a("t6_no_early_repeat", 8'h01);
    btn_n[0] = 1'b1;
    tick(12);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
